// File: rtl/alu_issue_pkg.sv
// Shared ALU-issue types: ALUop codes, MIPS opcode/funct fields,
// and the decoded-op bundle carried from decode into S1.
package alu_issue_pkg;

  typedef logic [3:0] aluop_t;

  localparam aluop_t ALU_AND  = 4'b0000;
  localparam aluop_t ALU_OR   = 4'b0001;
  localparam aluop_t ALU_ADD  = 4'b0010;
  localparam aluop_t ALU_SLL  = 4'b0011;
  localparam aluop_t ALU_LUI  = 4'b0100;
  localparam aluop_t ALU_SLTU = 4'b0101;
  localparam aluop_t ALU_SUB  = 4'b0110;
  localparam aluop_t ALU_SLT  = 4'b0111;
  localparam aluop_t ALU_NOR  = 4'b1000;
  localparam aluop_t ALU_XOR  = 4'b1001;
  localparam aluop_t ALU_SRL  = 4'b1010;
  localparam aluop_t ALU_SRA  = 4'b1011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  typedef struct packed {
    aluop_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        trap_en;
    logic        is_branch;
    logic        is_bne;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0, v};
  endfunction

endpackage

// File: rtl/alu_issue_alu.sv
// Combinational 32-bit ALU: op, a, b -> y, zero, ovf.
// Shifts move b by a[4:0]; LUI places b[15:0] in the upper half.
module alu_issue_alu
  import alu_issue_pkg::*;
(
  input  aluop_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero,
  output logic        ovf
);

  logic [31:0] sum;
  logic [31:0] dif;

  assign sum = a + b;
  assign dif = a - b;

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    unique case (op)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD: begin
        y   = sum;
        ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SLL:  y = b << a[4:0];
      ALU_LUI:  y = {b[15:0], 16'h0};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_SUB: begin
        y   = dif;
        ovf = (a[31] != b[31]) && (dif[31] != a[31]);
      end
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_NOR:  y = ~(a | b);
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = b >> a[4:0];
      ALU_SRA:  y = $signed(b) >>> a[4:0];
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_issue.sv
// Two-stage ALU issue pipe: decode into S1 (op/A/B), ALU into S2.
// Ports: valid/ready in (decoded fields), valid/ready out (result, flags).
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        trap_ov,
  output logic        illegal,
  output logic        is_branch,
  output logic        branch_taken
);

  dec_t        dec;
  dec_t        s1;
  logic        s1_valid;
  logic        s2_valid;
  logic        s2_load;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        alu_ovf;
  logic [31:0] sh_fix;
  logic [31:0] sh_var;

  assign sh_fix = {27'b0, shamt};
  assign sh_var = {27'b0, rs_val[4:0]};

  always_comb begin
    dec    = '0;
    dec.op = ALU_ADD;
    dec.a  = rs_val;
    dec.b  = rt_val;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          F_ADD: begin
            dec.op      = ALU_ADD;
            dec.trap_en = 1'b1;
          end
          F_ADDU: dec.op = ALU_ADD;
          F_SUB: begin
            dec.op      = ALU_SUB;
            dec.trap_en = 1'b1;
          end
          F_SUBU: dec.op = ALU_SUB;
          F_AND:  dec.op = ALU_AND;
          F_OR:   dec.op = ALU_OR;
          F_XOR:  dec.op = ALU_XOR;
          F_NOR:  dec.op = ALU_NOR;
          F_SLT:  dec.op = ALU_SLT;
          F_SLTU: dec.op = ALU_SLTU;
          F_SLL: begin
            dec.op = ALU_SLL;
            dec.a  = sh_fix;
          end
          F_SLLV: begin
            dec.op = ALU_SLL;
            dec.a  = sh_var;
          end
          F_SRL: begin
            dec.op = ALU_SRL;
            dec.a  = sh_fix;
          end
          F_SRLV: begin
            dec.op = ALU_SRL;
            dec.a  = sh_var;
          end
          F_SRA: begin
            dec.op = ALU_SRA;
            dec.a  = sh_fix;
          end
          F_SRAV: begin
            dec.op = ALU_SRA;
            dec.a  = sh_var;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec.op      = ALU_ADD;
        dec.b       = sext16(imm);
        dec.trap_en = 1'b1;
      end
      OP_ADDIU: begin
        dec.op = ALU_ADD;
        dec.b  = sext16(imm);
      end
      OP_SLTI: begin
        dec.op = ALU_SLT;
        dec.b  = sext16(imm);
      end
      OP_SLTIU: begin
        dec.op = ALU_SLTU;
        dec.b  = sext16(imm);
      end
      OP_ANDI: begin
        dec.op = ALU_AND;
        dec.b  = zext16(imm);
      end
      OP_ORI: begin
        dec.op = ALU_OR;
        dec.b  = zext16(imm);
      end
      OP_XORI: begin
        dec.op = ALU_XOR;
        dec.b  = zext16(imm);
      end
      OP_LUI: begin
        dec.op = ALU_LUI;
        dec.b  = zext16(imm);
      end
      OP_BEQ: begin
        dec.op        = ALU_SUB;
        dec.is_branch = 1'b1;
      end
      OP_BNE: begin
        dec.op        = ALU_SUB;
        dec.is_branch = 1'b1;
        dec.is_bne    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // S1 moves whenever S2 loads, even as a bubble.
  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1 <= dec;
    end
  end

  alu_issue_alu u_alu (
    .op   (s1.op),
    .a    (s1.a),
    .b    (s1.b),
    .y    (alu_y),
    .zero (alu_zero),
    .ovf  (alu_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      result       <= '0;
      trap_ov      <= 1'b0;
      illegal      <= 1'b0;
      is_branch    <= 1'b0;
      branch_taken <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result       <= s1.illegal ? '0 : alu_y;
        trap_ov      <= s1.trap_en & alu_ovf;
        illegal      <= s1.illegal;
        is_branch    <= s1.is_branch;
        branch_taken <= s1.is_branch & (s1.is_bne ^ alu_zero);
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: vector table pushed through a scoreboard,
// plus latency, backpressure, flush and async-reset sequences.
module tb_alu_issue;

  typedef struct {
    int          id;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [31:0] res;
    logic        tr;
    logic        il;
    logic        br;
    logic        tk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        trap_ov;
  logic        illegal;
  logic        is_branch;
  logic        branch_taken;

  alu_issue dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct        (funct),
    .shamt        (shamt),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .imm          (imm),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .trap_ov      (trap_ov),
    .illegal      (illegal),
    .is_branch    (is_branch),
    .branch_taken (branch_taken)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[31];
  vec_t q[$];
  vec_t cur;
  logic bp_rand = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input int id, input logic [5:0] op, input logic [5:0] fn,
    input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
    input logic [15:0] im, input logic [31:0] res,
    input logic tr, input logic il, input logic br, input logic tk);
    vec_t v;
    v.id = id; v.op = op; v.fn = fn; v.sh = sh;
    v.rs = rs; v.rt = rt; v.imm = im; v.res = res;
    v.tr = tr; v.il = il; v.br = br; v.tk = tk;
    return v;
  endfunction

  // Random consumer stalls during the second table pass.
  always begin
    @(posedge clk);
    #2;
    if (bp_rand) out_ready = 1'($urandom_range(0, 1));
  end

  logic        stall = 1'b0;
  logic [31:0] h_res;
  logic [3:0]  h_fl;

  always @(negedge clk) begin
    vec_t e;
    if (rst || flush) begin
      q.delete();
      stall = 1'b0;
    end else begin
      if (stall && out_valid) begin
        chk("hold result", result, h_res);
        chk("hold flags", {28'b0, trap_ov, illegal, is_branch, branch_taken},
            {28'b0, h_fl});
      end
      stall = out_valid && !out_ready;
      h_res = result;
      h_fl  = {trap_ov, illegal, is_branch, branch_taken};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected output: got %h want none", result);
        end else begin
          e = q.pop_front();
          chk($sformatf("v%0d result", e.id), result, e.res);
          chk1($sformatf("v%0d trap_ov", e.id), trap_ov, e.tr);
          chk1($sformatf("v%0d illegal", e.id), illegal, e.il);
          chk1($sformatf("v%0d is_branch", e.id), is_branch, e.br);
          chk1($sformatf("v%0d taken", e.id), branch_taken, e.tk);
        end
      end
      if (in_valid && in_ready) q.push_back(cur);
    end
  end

  task automatic drive(input int i);
    opcode = tbl[i].op;
    funct  = tbl[i].fn;
    shamt  = tbl[i].sh;
    rs_val = tbl[i].rs;
    rt_val = tbl[i].rt;
    imm    = tbl[i].imm;
    cur    = tbl[i];
    in_valid = 1'b1;
  endtask

  // Starts and ends at posedge+1.
  task automatic send(input int i);
    int   n = 0;
    logic acc = 1'b0;
    drive(i);
    do begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end while (!acc && n < 50);
    chk1($sformatf("v%0d accepted", i), acc, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(0,  6'h00, 6'h20, 5'd0, 32'h7fffffff, 32'h1, 16'h0, 32'h80000000, 1, 0, 0, 0);
    tbl[1]  = mk(1,  6'h00, 6'h21, 5'd0, 32'h7fffffff, 32'h1, 16'h0, 32'h80000000, 0, 0, 0, 0);
    tbl[2]  = mk(2,  6'h0a, 6'h00, 5'd0, 32'hffffffff, 32'h0, 16'h0, 32'h1, 0, 0, 0, 0);
    tbl[3]  = mk(3,  6'h0b, 6'h00, 5'd0, 32'hffffffff, 32'h0, 16'h0, 32'h0, 0, 0, 0, 0);
    tbl[4]  = mk(4,  6'h00, 6'h03, 5'd4, 32'h0, 32'h80000000, 16'h0, 32'hf8000000, 0, 0, 0, 0);
    tbl[5]  = mk(5,  6'h00, 6'h07, 5'd0, 32'h24, 32'h80000000, 16'h0, 32'hf8000000, 0, 0, 0, 0);
    tbl[6]  = mk(6,  6'h04, 6'h00, 5'd0, 32'h5, 32'h5, 16'h0, 32'h0, 0, 0, 1, 1);
    tbl[7]  = mk(7,  6'h05, 6'h00, 5'd0, 32'h5, 32'h5, 16'h0, 32'h0, 0, 0, 1, 0);
    tbl[8]  = mk(8,  6'h3f, 6'h20, 5'd0, 32'h12345678, 32'h9, 16'h0, 32'h0, 0, 1, 0, 0);
    tbl[9]  = mk(9,  6'h00, 6'h22, 5'd0, 32'h80000000, 32'h1, 16'h0, 32'h7fffffff, 1, 0, 0, 0);
    tbl[10] = mk(10, 6'h00, 6'h23, 5'd0, 32'h80000000, 32'h1, 16'h0, 32'h7fffffff, 0, 0, 0, 0);
    tbl[11] = mk(11, 6'h00, 6'h24, 5'd0, 32'hf0f0f0f0, 32'hff00ff00, 16'h0, 32'hf000f000, 0, 0, 0, 0);
    tbl[12] = mk(12, 6'h00, 6'h25, 5'd0, 32'hf0f0f0f0, 32'hff00ff00, 16'h0, 32'hfff0fff0, 0, 0, 0, 0);
    tbl[13] = mk(13, 6'h00, 6'h26, 5'd0, 32'hf0f0f0f0, 32'hff00ff00, 16'h0, 32'h0ff00ff0, 0, 0, 0, 0);
    tbl[14] = mk(14, 6'h00, 6'h27, 5'd0, 32'hf0f0f0f0, 32'hff00ff00, 16'h0, 32'h000f000f, 0, 0, 0, 0);
    tbl[15] = mk(15, 6'h00, 6'h2a, 5'd0, 32'hfffffffe, 32'h1, 16'h0, 32'h1, 0, 0, 0, 0);
    tbl[16] = mk(16, 6'h00, 6'h2b, 5'd0, 32'hfffffffe, 32'h1, 16'h0, 32'h0, 0, 0, 0, 0);
    tbl[17] = mk(17, 6'h00, 6'h00, 5'd8, 32'hffffffff, 32'h81, 16'h0, 32'h00008100, 0, 0, 0, 0);
    tbl[18] = mk(18, 6'h00, 6'h02, 5'd4, 32'h0, 32'h80000000, 16'h0, 32'h08000000, 0, 0, 0, 0);
    tbl[19] = mk(19, 6'h00, 6'h04, 5'd9, 32'h23, 32'h1, 16'h0, 32'h8, 0, 0, 0, 0);
    tbl[20] = mk(20, 6'h00, 6'h06, 5'd0, 32'h21, 32'hf0000000, 16'h0, 32'h78000000, 0, 0, 0, 0);
    tbl[21] = mk(21, 6'h08, 6'h00, 5'd0, 32'h7fffffff, 32'h0, 16'h0001, 32'h80000000, 1, 0, 0, 0);
    tbl[22] = mk(22, 6'h09, 6'h00, 5'd0, 32'h10, 32'h0, 16'hffff, 32'h0000000f, 0, 0, 0, 0);
    tbl[23] = mk(23, 6'h0c, 6'h00, 5'd0, 32'hffffffff, 32'h0, 16'h8001, 32'h00008001, 0, 0, 0, 0);
    tbl[24] = mk(24, 6'h0d, 6'h00, 5'd0, 32'h00010000, 32'h0, 16'h8000, 32'h00018000, 0, 0, 0, 0);
    tbl[25] = mk(25, 6'h0e, 6'h00, 5'd0, 32'hffffffff, 32'h0, 16'hffff, 32'hffff0000, 0, 0, 0, 0);
    tbl[26] = mk(26, 6'h0f, 6'h00, 5'd0, 32'h5, 32'h7, 16'h1234, 32'h12340000, 0, 0, 0, 0);
    tbl[27] = mk(27, 6'h00, 6'h3f, 5'd0, 32'h1, 32'h2, 16'h0, 32'h0, 0, 1, 0, 0);
    tbl[28] = mk(28, 6'h0b, 6'h00, 5'd0, 32'h0, 32'h0, 16'hffff, 32'h1, 0, 0, 0, 0);
    tbl[29] = mk(29, 6'h0a, 6'h00, 5'd0, 32'h5, 32'h0, 16'hffff, 32'h0, 0, 0, 0, 0);
    tbl[30] = mk(30, 6'h04, 6'h00, 5'd0, 32'h80000000, 32'h1, 16'h0, 32'h7fffffff, 0, 0, 1, 0);

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    opcode = '0; funct = '0; shamt = '0;
    rs_val = '0; rt_val = '0; imm = '0;
    cur = tbl[0];

    repeat (2) @(negedge clk);
    chk1("rst out_valid", out_valid, 1'b0);
    chk("rst result", result, 32'h0);
    chk1("rst trap_ov", trap_ov, 1'b0);
    chk1("rst illegal", illegal, 1'b0);
    chk1("rst is_branch", is_branch, 1'b0);
    chk1("rst taken", branch_taken, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("post-rst in_ready", in_ready, 1'b1);
    idle(1);

    // slti then sltiu back to back: latency 2, consecutive outputs.
    send(2);
    chk1("lat1 out_valid", out_valid, 1'b0);
    send(3);
    chk1("lat2 out_valid", out_valid, 1'b1);
    chk("lat2 result", result, 32'h1);
    idle(1);
    chk1("lat3 out_valid", out_valid, 1'b1);
    chk("lat3 result", result, 32'h0);
    idle(3);

    for (int i = 0; i < 31; i++) send(i);
    idle(4);
    chk("pass1 drained", q.size(), 32'd0);

    bp_rand = 1'b1;
    for (int i = 30; i >= 0; i--) send(i);
    bp_rand = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("pass2 drained", q.size(), 32'd0);

    // Backpressure: third op refused while both stages hold.
    out_ready = 1'b0;
    send(11);
    send(12);
    drive(13);
    @(negedge clk);
    chk1("bp in_ready", in_ready, 1'b0);
    chk1("bp out_valid", out_valid, 1'b1);
    chk("bp head", result, tbl[11].res);
    idle(1);
    @(negedge clk);
    chk1("bp in_ready 2", in_ready, 1'b0);
    idle(1);
    out_ready = 1'b1;
    @(negedge clk);
    chk1("bp release", in_ready, 1'b1);
    idle(1);
    in_valid = 1'b0;
    idle(4);
    chk("bp drained", q.size(), 32'd0);

    // Flush with both stages full overrides a same-cycle accept.
    out_ready = 1'b0;
    send(0);
    send(1);
    chk1("fl pre out_valid", out_valid, 1'b1);
    drive(2);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk1("fl out_valid", out_valid, 1'b0);
    idle(1);
    chk1("fl out_valid 2", out_valid, 1'b0);
    out_ready = 1'b1;
    idle(2);
    chk1("fl out_valid 3", out_valid, 1'b0);

    // Async reset mid-stream.
    send(4);
    send(5);
    chk1("ar pre out_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("ar out_valid", out_valid, 1'b0);
    chk("ar result", result, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("ar post out_valid", out_valid, 1'b0);
    chk1("ar in_ready", in_ready, 1'b1);
    idle(3);
    chk1("ar quiet", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit datapath, 4-bit ALUop).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  decoded instruction present.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 opcode  input  6  MIPS opcode field.
REQ-007 funct  input  6  MIPS funct field (R-type only).
REQ-008 shamt  input  5  shift amount field.
REQ-009 rs_val  input  32  rs register value.
REQ-010 rt_val  input  32  rt register value.
REQ-011 imm  input  16  immediate field.
REQ-012 flush  input  1  synchronous pipeline kill.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer takes the result this cycle.
REQ-015 result  output  32  ALU Result (0 when illegal).
REQ-016 trap_ov  output  1  signed overflow on add, sub or addi.
REQ-017 illegal  output  1  unsupported opcode/funct.
REQ-018 is_branch, branch_taken  output  1 each  beq/bne marker and outcome.

Function
REQ-019 The block SHALL be a two-stage pipeline: S1 registers decoded ALUop, A and B; S2 registers alu outputs; an accepted instruction SHALL reach out_valid exactly 2 cycles later when unstalled.
REQ-020 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready; S2 loads when !s2_valid||out_ready; S1 advances when S2 loads; in_ready = !s1_valid || S1 advances. Full throughput of 1 op/cycle is required.
REQ-021 While out_valid && !out_ready, every output SHALL hold stable.
REQ-022 R-type decode (opcode 000000): funct 100000/100001 -> ADD; 100010/100011 -> SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU; 000000/000100 SLL; 000010/000110 SRL; 000011/000111 SRA.
REQ-023 I-type: 001000/001001 ADD, sign-extended imm; 001010 SLT, sign-extended; 001011 SLTU, sign-extended; 001100 AND, 001101 OR, 001110 XOR, zero-extended; 001111 LUI with B=imm; 000100/000101 (beq/bne) SUB with B=rt_val.
REQ-024 Shifts: A = {27'b0, shamt} for fixed forms and {27'b0, rs_val[4:0]} for variable forms; B = rt_val. Other ops use A = rs_val.
REQ-025 trap_ov SHALL equal alu Overflow only for add, sub and addi; it SHALL be 0 for addu, subu, addiu, slt(i)(u) and branches.
REQ-026 branch_taken: beq = Zero, bne = !Zero; both 0 when is_branch=0.
REQ-027 Any other opcode/funct SHALL set illegal=1 with result=0, trap_ov=0 and is_branch=0, and SHALL still occupy a pipeline slot.
REQ-028 flush SHALL clear s1_valid and s2_valid at the next edge, overriding a same-cycle input acceptance; in_ready is don't-care during flush.

Reset
REQ-029 On rst: s1_valid=0, s2_valid=0, out_valid=0, result=0, trap_ov=0, illegal=0, is_branch=0, branch_taken=0; in_ready=1 right after reset release.
REQ-030 An asserted rst mid-transfer SHALL discard all in-flight instructions without any output pulse.

Structure
REQ-031 The shared package SHALL hold the ALUop constants (AND 0000, OR 0001, ADD 0010, SLL 0011, LUI 0100, SLTU 0101, SUB 0110, SLT 0111, NOR 1000, XOR 1001, SRL 1010, SRA 1011), opcode/funct constants and the decoded-op struct.
REQ-032 One sub-module instance SHALL be used: the team's existing combinational alu, placed between S1 and S2.

Verification
REQ-033 add: rs=0x7FFFFFFF, rt=1 -> result 0x80000000, trap_ov=1; the same operands with addu -> trap_ov=0.
REQ-034 Back-to-back: slti with rs=0xFFFFFFFF, imm=0x0000 then sltiu with the same operands -> results 1 then 0 on consecutive cycles, latency 2.
REQ-035 sra with rt=0x80000000, shamt=4 -> 0xF8000000; srav with rs=0x24 (amount 4) -> same.
REQ-036 Backpressure: out_ready=0 for 3 cycles while 3 ops are issued -> in_ready falls after 2 accepts, outputs stay stable, then all 3 ops drain in order.
REQ-037 beq with rs=rt=5 -> branch_taken=1; bne with the same operands -> 0; opcode 111111 -> illegal=1, result 0.
REQ-038 flush with both stages full -> out_valid=0 next cycle; async rst mid-stream -> out_valid drops immediately.
